// File: rtl/sipo_ctrl_pkg.sv
// Shared types and helpers for the SIPO frame controller.
// Optional feature macro: SIPO_PARITY_CHECK_EN (adds the PARITY state).
package sipo_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_PARITY  = 2'd2,
        ST_CAPTURE = 2'd3
    } state_e;

    // Even-parity bit over a zero-extended word (XOR reduce).
    function automatic logic even_parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sipo_out_hold.sv
// Output holding register with valid/ready handshake and sticky overrun.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   capture_i       - load request carrying word_i
//   word_i          - word to capture
//   out_ready_i     - consumer accepts data_o when valid_o=1
//   clr_err_i       - clears overrun_o (a coincident new overrun wins)
//   data_o/valid_o  - held word and its valid flag
//   overrun_o       - sticky: a captured word was dropped
module sipo_out_hold #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             capture_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             out_ready_i,
    input  logic             clr_err_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             drop_c;

    // A capture is accepted when the register is empty or is being drained this cycle.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        drop_c  = 1'b0;
        if (capture_i) begin
            if (!valid_q || out_ready_i) begin
                data_d  = word_i;
                valid_d = 1'b1;
            end else begin
                drop_c = 1'b1;
            end
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
        overrun_d = (overrun_q & ~clr_err_i) | drop_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer for an external WIDTH-bit SIPO shift register: gates the
// SIPO shift enable, counts bits, captures the parallel word and hands it on
// over valid/ready. Optional macro SIPO_PARITY_CHECK_EN adds a trailing even
// parity bit (parity_bit in, sticky parity_err out).
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   frame_start         - pulse starting (or restarting) a frame
//   bit_valid           - serial bit present this cycle
//   shift               - combinational SIPO shift enable
//   par_in              - SIPO parallel contents
//   data_out/out_valid  - captured word and valid; out_ready accepts it
//   busy                - frame in progress
//   frame_err           - one-cycle pulse on a frame aborted by frame_start
//   overrun             - sticky word-dropped flag; clr_err clears it
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             bit_valid,
    output logic             shift,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
`ifdef SIPO_PARITY_CHECK_EN
    input  logic             parity_bit,
    output logic             parity_err,
`endif
    input  logic             clr_err
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_err_q, frame_err_d;
    logic             capture_c;
`ifdef SIPO_PARITY_CHECK_EN
    logic             parity_err_q, parity_err_d;
`endif

    // Next-state, bit counter and SIPO shift enable.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_err_d = 1'b0;
        shift       = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
        parity_err_d = parity_err_q & ~clr_err;
`endif
        case (state_q)
            ST_IDLE: begin
                // A bit arriving with frame_start is not part of the frame.
                if (frame_start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                shift = bit_valid;
                if (frame_start) begin
                    // Restart: a coincident bit becomes bit 0 of the new frame.
                    frame_err_d = 1'b1;
                    cnt_d       = bit_valid ? CNT_W'(1) : '0;
                end else if (bit_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
`ifdef SIPO_PARITY_CHECK_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_CAPTURE;
`endif
                    end
                end
            end
`ifdef SIPO_PARITY_CHECK_EN
            ST_PARITY: begin
                // The parity bit is consumed here and never shifted into the SIPO.
                if (frame_start) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_SHIFT;
                    cnt_d       = '0;
                end else if (bit_valid) begin
                    state_d = ST_CAPTURE;
                    if (parity_bit != even_parity(32'(par_in))) begin
                        parity_err_d = 1'b1;
                    end
                end
            end
`endif
            ST_CAPTURE: begin
                cnt_d   = '0;
                state_d = frame_start ? ST_SHIFT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef SIPO_PARITY_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

    // par_in holds the complete word during the CAPTURE cycle.
    assign capture_c = (state_q == ST_CAPTURE);

    sipo_out_hold #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk         (clk),
        .reset       (reset),
        .capture_i   (capture_c),
        .word_i      (par_in),
        .out_ready_i (out_ready),
        .clr_err_i   (clr_err),
        .data_o      (data_out),
        .valid_o     (out_valid),
        .overrun_o   (overrun)
    );

    assign busy      = (state_q != ST_IDLE);
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl with a behavioural 8-bit SIPO and
// a scoreboard of expected delivered words.
module tb_sipo_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       bit_valid;
    logic       shift;
    logic [7:0] par_in;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       clr_err;
`ifdef SIPO_PARITY_CHECK_EN
    logic       parity_bit;
    logic       parity_err;
`endif

    logic       ser;
    logic [7:0] sipo = 8'h00;
    int         errors = 0;
    int         checks = 0;
    int         shift_cnt = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    sipo_frame_ctrl #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .bit_valid   (bit_valid),
        .shift       (shift),
        .par_in      (par_in),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun     (overrun),
`ifdef SIPO_PARITY_CHECK_EN
        .parity_bit  (parity_bit),
        .parity_err  (parity_err),
`endif
        .clr_err     (clr_err)
    );

    // External SIPO model, MSB first.
    always @(posedge clk) begin
        if (shift) sipo <= {sipo[6:0], ser};
    end
    assign par_in = sipo;

    always @(negedge clk) begin
        if (shift) shift_cnt++;
    end

    // Scoreboard monitor: compare on every accepted transfer.
    always @(negedge clk) begin
        logic [7:0] exp_w;
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: data_out=%h with no word expected", data_out);
            end else begin
                exp_w = sb.pop_front();
                if (data_out !== exp_w) begin
                    errors++;
                    $display("FAIL sb_data: got %h, expected %h", data_out, exp_w);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            ser       = w[i];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
    endtask

`ifdef SIPO_PARITY_CHECK_EN
    task automatic end_parity(input logic p);
        parity_bit = p;
        bit_valid  = 1'b1;
        tick();
        bit_valid  = 1'b0;
        parity_bit = 1'b0;
    endtask
`endif

    // Leaves the DUT in the CAPTURE cycle.
    task automatic frame(input logic [7:0] w);
        start();
        send_bits(w, 7, 0);
`ifdef SIPO_PARITY_CHECK_EN
        end_parity(^w);
`endif
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int s0;
        reset = 1'b1; frame_start = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
        clr_err = 1'b0; ser = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
        parity_bit = 1'b0;
`endif
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_data_out",  32'(data_out),  0);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_overrun",   32'(overrun),   0);
        reset = 1'b0;
        tick();

        // Basic frame A5: 8 shifts, valid one cycle after the last bit.
        shift_cnt = 0;
        sb.push_back(8'hA5);
        frame(8'hA5);
        chk("a5_shifts",     32'(shift_cnt), 8);
        chk("a5_valid_pre",  32'(out_valid), 0);
        chk("a5_busy_pre",   32'(busy),      1);
        tick();
        chk("a5_valid",      32'(out_valid), 1);
        chk("a5_busy_post",  32'(busy),      0);
        chk("a5_data",       32'(data_out),  32'h A5);
        drain();
        chk("a5_valid_clr",  32'(out_valid), 0);

        // Overrun: 3C held, C3 dropped.
        sb.push_back(8'h3C);
        frame(8'h3C); tick();
        frame(8'hC3); tick();
        chk("ovr_flag",      32'(overrun),   1);
        chk("ovr_data",      32'(data_out),  32'h3C);
        chk("ovr_valid",     32'(out_valid), 1);
        drain();
        chk("ovr_valid_clr", 32'(out_valid), 0);
        chk("ovr_sticky",    32'(overrun),   1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("ovr_cleared",   32'(overrun),   0);

        // Capture while the previous word is consumed in the same cycle.
        sb.push_back(8'h55);
        frame(8'h55); tick();
        frame(8'h0F);
        sb.push_back(8'h0F);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("cc_valid",      32'(out_valid), 1);
        chk("cc_overrun",    32'(overrun),   0);
        chk("cc_data",       32'(data_out),  32'h0F);
        drain();

        // Restart after 5 bits: frame_err pulse, 8 more bits needed.
        start();
        send_bits(8'hFF, 7, 3);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("fe_pulse",      32'(frame_err), 1);
        tick();
        chk("fe_one_cycle",  32'(frame_err), 0);
        chk("fe_busy",       32'(busy),      1);
        sb.push_back(8'h96);
        send_bits(8'h96, 7, 1);
        chk("fe_7bits_noval", 32'(out_valid), 0);
        send_bits(8'h96, 0, 0);
`ifdef SIPO_PARITY_CHECK_EN
        end_parity(^(8'h96));
`endif
        tick();
        chk("fe_valid",      32'(out_valid), 1);
        drain();

        // Restart with a coincident bit: that bit is bit 0 of the new frame.
        start();
        send_bits(8'h00, 7, 5);
        sb.push_back(8'hB4);
        shift_cnt = 0;
        ser = 1'b1; bit_valid = 1'b1; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; bit_valid = 1'b0;
        chk("rs_shift_cnt",  32'(shift_cnt), 1);
        chk("rs_frame_err",  32'(frame_err), 1);
        send_bits(8'hB4, 6, 0);
`ifdef SIPO_PARITY_CHECK_EN
        end_parity(^(8'hB4));
`endif
        tick();
        chk("rs_valid",      32'(out_valid), 1);
        drain();

        // frame_start with bit_valid in IDLE: bit ignored.
        s0 = shift_cnt;
        ser = 1'b1; bit_valid = 1'b1; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; bit_valid = 1'b0;
        chk("idle_bit_ignored", 32'(shift_cnt - s0), 0);
        sb.push_back(8'h5A);
        send_bits(8'h5A, 7, 0);
`ifdef SIPO_PARITY_CHECK_EN
        end_parity(^(8'h5A));
`endif
        tick();
        chk("idle_valid",    32'(out_valid), 1);
        drain();

        // Reset mid-frame with a word held.
        frame(8'h11); tick();
        chk("mr_valid_pre",  32'(out_valid), 1);
        start();
        send_bits(8'hFF, 7, 4);
        reset = 1'b1;
        #1;
        chk("mr_valid",      32'(out_valid), 0);
        chk("mr_data",       32'(data_out),  0);
        chk("mr_busy",       32'(busy),      0);
        tick();
        reset = 1'b0;
        tick();
        sb.push_back(8'hE7);
        frame(8'hE7); tick();
        chk("mr_next_valid", 32'(out_valid), 1);
        drain();

`ifdef SIPO_PARITY_CHECK_EN
        // Parity: 01 with parity_bit 0 mismatches, 03 with 0 matches.
        shift_cnt = 0;
        sb.push_back(8'h01);
        start();
        send_bits(8'h01, 7, 0);
        end_parity(1'b0);
        tick();
        chk("par_err_set",   32'(parity_err), 1);
        chk("par_shifts",    32'(shift_cnt),  8);
        chk("par_data",      32'(data_out),   32'h01);
        drain();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("par_err_clr",   32'(parity_err), 0);
        sb.push_back(8'h03);
        start();
        send_bits(8'h03, 7, 0);
        end_parity(1'b0);
        tick();
        chk("par_err_ok",    32'(parity_err), 0);
        drain();
`endif

        tick();
        chk("sb_empty",      32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
